// File: rtl/common.sv
// Shared pipeline types: forwarding selects, per-stage destination tags and
// the forwarding decision used for both execute-stage operands.
package common;

    // Register index width the stage tags are built with.
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        EX_MEM = 2'd1,
        MEM_WB = 2'd2
    } forwarding_type;

    // Destination bookkeeping for one in-flight instruction.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_tag_type;

    // A tag produces register r when it is live, writes, targets r, and r is not x0.
    function automatic logic tag_writes(input stage_tag_type tag,
                                        input logic [REG_ADDR_W-1:0] r);
        return tag.valid && tag.reg_write && (tag.rd == r) && (r != '0);
    endfunction

    // Youngest producer wins: the instruction now in EX sits in MEM while the
    // consumer executes, the one now in MEM sits in WB.
    function automatic forwarding_type fwd_select(input logic [REG_ADDR_W-1:0] src,
                                                  input logic                  uses,
                                                  input stage_tag_type         ex_tag,
                                                  input stage_tag_type         mem_tag);
        forwarding_type sel;
        sel = NONE;
        if (uses && tag_writes(ex_tag, src)) begin
            sel = EX_MEM;
        end else if (uses && tag_writes(mem_tag, src)) begin
            sel = MEM_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Execute-stage operand forwarding and load-use stall control for the
// 5-stage pipeline. Tracks destination tags of the instructions in EX, MEM
// and WB, registers the forwarding selects so they line up with the
// consumer's EX cycle, and counts load-use stall cycles (saturating).
module hazard_unit
    import common::*;
#(
    parameter int REG_ADDR_WIDTH  = common::REG_ADDR_W,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       id_valid,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rs2,
    input  logic                       id_uses_rs1,
    input  logic                       id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rd,
    input  logic                       id_reg_write,
    input  logic                       id_mem_read,
    input  logic                       flush,
    output logic                       stall,
    output forwarding_type             ctrl_forward_left_operand,
    output forwarding_type             ctrl_forward_right_operand,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    localparam logic [STALL_CNT_WIDTH-1:0] STALL_CNT_MAX = {STALL_CNT_WIDTH{1'b1}};

    stage_tag_type ex_tag_q, ex_tag_d;
    stage_tag_type mem_tag_q;
    stage_tag_type wb_tag_q;

    forwarding_type fwd_left_q,  fwd_left_d;
    forwarding_type fwd_right_q, fwd_right_d;

    logic [STALL_CNT_WIDTH-1:0] stall_count_q, stall_count_d;

    logic load_use;

    // The WB tag is kept for pipeline visibility only; the register file's
    // write-through bypass covers the WB-to-ID case, so nothing here reads it.
    logic unused_wb_tag;
    assign unused_wb_tag = ^wb_tag_q;

    // Load in EX whose destination the ID instruction reads: one bubble needed.
    always_comb begin
        load_use = id_valid && ex_tag_q.valid && ex_tag_q.mem_read && (ex_tag_q.rd != '0)
                && ((id_uses_rs1 && (id_rs1 == ex_tag_q.rd))
                 || (id_uses_rs2 && (id_rs2 == ex_tag_q.rd)));
    end

    // A taken branch kills the ID instruction, so it can never stall.
    assign stall = load_use && !flush;

    // Next EX tag, next forwarding selects and next stall count.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        ex_tag_d      = '0;
        fwd_left_d    = NONE;
        fwd_right_d   = NONE;
        stall_count_d = stall_count_q;

        if (flush) begin
            // Bubble with NONE selects; the stall counter is untouched.
        end else if (stall) begin
            if (stall_count_q != STALL_CNT_MAX) begin
                stall_count_d = stall_count_q + 1'b1;
            end
        end else begin
            ex_tag_d.valid     = id_valid;
            ex_tag_d.rd        = id_rd;
            ex_tag_d.reg_write = id_reg_write;
            ex_tag_d.mem_read  = id_mem_read;
            fwd_left_d  = fwd_select(id_rs1, id_uses_rs1, ex_tag_q, mem_tag_q);
            fwd_right_d = fwd_select(id_rs2, id_uses_rs2, ex_tag_q, mem_tag_q);
        end
    end

    // Advance the stage tags, selects and counter; reset clears everything at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_tag_q      <= '0;
            mem_tag_q     <= '0;
            wb_tag_q      <= '0;
            fwd_left_q    <= NONE;
            fwd_right_q   <= NONE;
            stall_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; mem_tag_q must see the old ex_tag_q.
            wb_tag_q      <= mem_tag_q;
            mem_tag_q     <= ex_tag_q;
            ex_tag_q      <= ex_tag_d;
            fwd_left_q    <= fwd_left_d;
            fwd_right_q   <= fwd_right_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ctrl_forward_left_operand  = fwd_left_q;
    assign ctrl_forward_right_operand = fwd_right_q;
    assign stall_count                = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed instruction sequences, a
// history-based reference model checked every cycle, and hand-computed
// literal expectations at the key points.
module tb_hazard_unit;
    import common::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_uses_rs1 = 1'b0;
    logic       id_uses_rs2 = 1'b0;
    logic [4:0] id_rd = '0;
    logic       id_reg_write = 1'b0;
    logic       id_mem_read = 1'b0;
    logic       flush = 1'b0;

    logic           stall, stall_s;
    forwarding_type fwd_l, fwd_r, fwd_l_s, fwd_r_s;
    logic [15:0]    stall_count;
    logic [3:0]     stall_count_s;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .stall(stall),
        .ctrl_forward_left_operand(fwd_l), .ctrl_forward_right_operand(fwd_r),
        .stall_count(stall_count)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    hazard_unit #(.STALL_CNT_WIDTH(4)) dut_small (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .stall(stall_s),
        .ctrl_forward_left_operand(fwd_l_s), .ctrl_forward_right_operand(fwd_r_s),
        .stall_count(stall_count_s)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // History of what entered EX on each edge; the last entry is in EX,
    // the one before it is in MEM.
    typedef struct {
        bit valid;
        int rd;
        bit wr;
        bit ld;
    } instr_t;

    instr_t hist[$];
    int m_left = 0;
    int m_right = 0;
    int m_cnt = 0;
    int m_cnt_small = 0;

    function automatic instr_t in_flight(input int age);
        instr_t r;
        r = '{valid: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
        if (hist.size() > age) r = hist[hist.size() - 1 - age];
        return r;
    endfunction

    function automatic bit reads(input int r);
        return (id_uses_rs1 && int'(id_rs1) == r) || (id_uses_rs2 && int'(id_rs2) == r);
    endfunction

    function automatic bit m_stall();
        instr_t e;
        e = in_flight(0);
        return id_valid && !flush && e.valid && e.ld && e.rd != 0 && reads(e.rd);
    endfunction

    // age 0 (in EX now) is MEM during consumer's EX -> EX_MEM (1);
    // age 1 (in MEM now) is WB then -> MEM_WB (2).
    function automatic int m_fwd(input bit uses, input int src);
        instr_t p;
        if (!uses || src == 0) return 0;
        for (int age = 0; age < 2; age++) begin
            p = in_flight(age);
            if (p.valid && p.wr && p.rd == src) return age + 1;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        instr_t n;
        if (!reset_n) begin
            hist.delete();
            m_left = 0; m_right = 0; m_cnt = 0; m_cnt_small = 0;
        end else begin
            n = '{valid: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
            if (flush) begin
                m_left = 0; m_right = 0;
            end else if (m_stall()) begin
                m_left = 0; m_right = 0;
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_small < 15) m_cnt_small++;
            end else begin
                m_left  = m_fwd(id_uses_rs1, int'(id_rs1));
                m_right = m_fwd(id_uses_rs2, int'(id_rs2));
                n = '{valid: id_valid, rd: int'(id_rd), wr: id_reg_write, ld: id_mem_read};
            end
            hist.push_back(n);
            if (hist.size() > 4) void'(hist.pop_front());
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        check("m_stall", int'(stall), int'(m_stall()));
        check("m_left", int'(fwd_l), m_left);
        check("m_right", int'(fwd_r), m_right);
        check("m_count", int'(stall_count), m_cnt);
        check("m_stall_small", int'(stall_s), int'(m_stall()));
        check("m_count_small", int'(stall_count_s), m_cnt_small);
    end

    // ---------------- stimulus ----------------
    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2,
                          input bit u2, input int rd, input bit wr, input bit ld);
        id_valid = v;
        id_rs1 = 5'(rs1); id_uses_rs1 = u1;
        id_rs2 = 5'(rs2); id_uses_rs2 = u2;
        id_rd = 5'(rd); id_reg_write = wr; id_mem_read = ld;
        flush = 1'b0;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nop();
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        check("reset_stall", int'(stall), 0);
        check("reset_left", int'(fwd_l), int'(NONE));
        check("reset_right", int'(fwd_r), int'(NONE));
        check("reset_count", int'(stall_count), 0);
        tick();

        // add x5,x1,x2 ; add x6,x5,x1
        set_id(1, 1, 1, 2, 1, 5, 1, 0); tick();
        set_id(1, 5, 1, 1, 1, 6, 1, 0); #1 check("raw_stall", int'(stall), 0); tick();
        check("raw_left", int'(fwd_l), int'(EX_MEM));
        check("raw_right", int'(fwd_r), int'(NONE));
        nop(); tick(); tick();

        // add x5 ; nop ; sub x7,x1,x5
        set_id(1, 1, 1, 2, 1, 5, 1, 0); tick();
        nop(); tick();
        set_id(1, 1, 1, 5, 1, 7, 1, 0); tick();
        check("dist2_left", int'(fwd_l), int'(NONE));
        check("dist2_right", int'(fwd_r), int'(MEM_WB));
        nop(); tick(); tick();

        // add x5 ; add x5 ; add x8,x5,x5 -> youngest wins
        set_id(1, 1, 1, 2, 1, 5, 1, 0); tick();
        set_id(1, 3, 1, 4, 1, 5, 1, 0); tick();
        set_id(1, 5, 1, 5, 1, 8, 1, 0); tick();
        check("prio_left", int'(fwd_l), int'(EX_MEM));
        check("prio_right", int'(fwd_r), int'(EX_MEM));
        nop(); tick(); tick();

        // lw x5 ; add x6,x5,x5 -> one stall, then MEM_WB on both
        set_id(1, 1, 1, 0, 0, 5, 1, 1); tick();
        set_id(1, 5, 1, 5, 1, 6, 1, 0); #1 check("lu_stall", int'(stall), 1); tick();
        check("lu_bubble_left", int'(fwd_l), int'(NONE));
        check("lu_stall_released", int'(stall), 0);
        tick();
        check("lu_left", int'(fwd_l), int'(MEM_WB));
        check("lu_right", int'(fwd_r), int'(MEM_WB));
        check("lu_count", int'(stall_count), 1);
        nop(); tick(); tick();

        // lw x5 ; consumer with flush in the same cycle
        set_id(1, 1, 1, 0, 0, 5, 1, 1); tick();
        set_id(1, 5, 1, 5, 1, 6, 1, 0); flush = 1'b1;
        #1 check("flush_stall", int'(stall), 0); tick();
        flush = 1'b0;
        check("flush_left", int'(fwd_l), int'(NONE));
        check("flush_right", int'(fwd_r), int'(NONE));
        check("flush_count", int'(stall_count), 1);
        nop(); tick(); tick();

        // addi x0 ; use x0
        set_id(1, 1, 1, 0, 0, 0, 1, 0); tick();
        set_id(1, 0, 1, 0, 1, 9, 1, 0); tick();
        check("x0_left", int'(fwd_l), int'(NONE));
        check("x0_right", int'(fwd_r), int'(NONE));
        nop(); tick(); tick();

        // lw x0 ; use x0
        set_id(1, 1, 1, 0, 0, 0, 1, 1); tick();
        set_id(1, 0, 1, 0, 1, 9, 1, 0); #1 check("x0_load_stall", int'(stall), 0); tick();
        nop(); tick(); tick();

        // 19 further load-use stalls: narrow counter saturates at 0xF
        for (int i = 0; i < 19; i++) begin
            set_id(1, 2, 1, 0, 0, 9, 1, 1); tick();
            set_id(1, 3, 1, 9, 1, 10, 1, 0); tick();
            tick();
            nop();
        end
        tick(); tick();
        check("sat_small", int'(stall_count_s), 15);
        check("count_main", int'(stall_count), 20);

        // Reset mid-cycle with live tags and a non-NONE select
        set_id(1, 1, 1, 2, 1, 5, 1, 0); tick();
        set_id(1, 5, 1, 5, 1, 6, 1, 0); tick();
        check("pre_reset_left", int'(fwd_l), int'(EX_MEM));
        #1 reset_n = 1'b0;
        #1;
        check("async_left", int'(fwd_l), int'(NONE));
        check("async_right", int'(fwd_r), int'(NONE));
        check("async_count", int'(stall_count), 0);
        nop();
        tick();
        reset_n = 1'b1;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
